gf2_row_systemizer: RTL and testbench
=====================================

GF2_ROW_SYSTEMIZER -- requirements
Module: gf2_row_systemizer

Interface
REQ-001 SHALL have parameter ROWS, default 8: matrix row count, and pivot count.
REQ-002 SHALL have parameter COLS, default 16: row width in bits; COLS >= ROWS; column j = bit j.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start  in  1  begin elimination on loaded matrix.
REQ-006 SHALL have port ld_valid / ld_ready  in / out  1 / 1  row-load handshake.
REQ-007 SHALL have port ld_data  in  COLS  row being loaded.
REQ-008 SHALL have port rd_valid / rd_ready  out / in  1 / 1  row-unload handshake.
REQ-009 SHALL have port rd_data  out  COLS  row being unloaded.
REQ-010 SHALL have port busy  out  1  high in SEARCH or ELIM.
REQ-011 SHALL have port done  out  1  one-cycle pulse when elimination ends.
REQ-012 SHALL have port success / fail  out / out  1 / 1  result flags, held until the next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, SEARCH, ELIM, UNLOAD.
REQ-014 In IDLE, ld_ready SHALL be 1 while fewer than ROWS rows are loaded; each ld_valid&ld_ready SHALL write row ld_ptr and increment ld_ptr.
REQ-015 start SHALL be accepted only in IDLE with ld_ptr==ROWS; otherwise it is ignored. Acceptance clears success/fail and sets pivot i=0, next state SEARCH.
REQ-016 SEARCH SHALL examine row i+k on its k-th cycle. If bit i is 1: swap rows i and i+k at that edge, go to ELIM. If k reaches ROWS-i with no hit: set fail, pulse done, go to UNLOAD.
REQ-017 ELIM SHALL take exactly ROWS cycles, one row r per cycle (r=0..ROWS-1). For r!=i with row[r] bit i = 1, row[r] ^= row[i]. Rows with r==i, or with bit i = 0, are unchanged.
REQ-018 After the last ELIM cycle, i SHALL increment. If i==ROWS: set success, pulse done, go to UNLOAD. Otherwise return to SEARCH.
REQ-019 Best-case latency (no swaps) SHALL be ROWS*(ROWS+1) cycles from the start edge to the done cycle. Each extra search step adds 1 cycle.
REQ-020 In UNLOAD, rd_valid SHALL be 1 and rd_data SHALL present row rd_ptr. rd_ptr advances on rd_valid&rd_ready. rd_data SHALL stay stable while rd_ready=0.
REQ-021 After the ROWS-th transfer, the block SHALL clear ld_ptr and rd_ptr and return to IDLE. rd_valid SHALL be 0 outside UNLOAD.
REQ-022 UNLOAD SHALL occur after fail as well as after success; on fail, rows hold their partially reduced contents.
REQ-023 ld_valid outside IDLE and start outside IDLE SHALL be ignored.

Reset
REQ-024 rst_n low SHALL, at any time including mid-SEARCH/ELIM/UNLOAD, force IDLE; clear all rows, ld_ptr, rd_ptr and i to 0; and drive busy=done=success=fail=rd_valid=0 and ld_ready=1.

Configuration
REQ-025 With GF2_SYS_CYCLE_COUNT_EN defined, the block SHALL add output cycle_cnt (16 bits). cycle_cnt clears on accepted start, counts each SEARCH/ELIM cycle, saturates at 0xFFFF, holds otherwise, and resets to 0.
REQ-026 Without GF2_SYS_CYCLE_COUNT_EN, the cycle_cnt port and its counter SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-027 Package gf2_sys_pkg SHALL hold the FSM state typedef and the row-index width function (clog2 of ROWS+1).
REQ-028 The row array with load-write, swap, XOR-update and read mux SHALL be sub-module gf2_row_file; gf2_row_systemizer holds the FSM and pointers.

Verification (ROWS=4, COLS=8)
REQ-029 Load 0x11,0x22,0x44,0x88; start -> done at cycle 20, success=1; unload 0x11,0x22,0x44,0x88.
REQ-030 Load 0x02,0x01,0x04,0x08 -> one swap, done at cycle 21, success=1; unload 0x01,0x02,0x04,0x08.
REQ-031 Load 0x53,0x22,0x04,0x08 -> success=1; unload 0x71,0x22,0x04,0x08.
REQ-032 Load 0x03,0x03,0x04,0x08 -> fail=1, success=0, done pulses once; four rows unload, then return to IDLE.
REQ-033 With rd_ready held 0 for 5 cycles, rd_data SHALL be stable.
REQ-034 rst_n low mid-ELIM -> IDLE with all outputs at reset values.
REQ-035 start after only 3 rows are loaded SHALL be ignored.

Source files
------------

// File: rtl/gf2_sys_pkg.sv
// Shared types and sizing helpers for the GF(2) row systemizer.
// Optional cycle counter is enabled by defining GF2_SYS_CYCLE_COUNT_EN.
package gf2_sys_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    ELIM,
    UNLOAD
  } state_t;

  // Wide enough to hold every row index and the terminal value ROWS.
  function automatic int idx_width(input int rows);
    return $clog2(rows + 1);
  endfunction

  // Width of an address into an array of `rows` entries.
  function automatic int addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/gf2_row_file.sv
// Row storage for the systemizer: load write, pivot swap, conditional XOR
// elimination, a search read port and an unload read port.
module gf2_row_file
  import gf2_sys_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 16,
  parameter int AW   = addr_width(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_en,
  input  logic [AW-1:0]   swap_a,
  input  logic [AW-1:0]   swap_b,
  input  logic            elim_en,
  input  logic [AW-1:0]   elim_addr,
  input  logic [AW-1:0]   piv_addr,
  input  logic [AW-1:0]   search_addr,
  output logic [COLS-1:0] search_row,
  input  logic [AW-1:0]   rd_addr,
  output logic [COLS-1:0] rd_data
);

  logic [COLS-1:0] rows [ROWS];
  logic [COLS-1:0] piv_mask;
  logic            elim_hit;

  assign piv_mask   = COLS'(1) << piv_addr;
  assign elim_hit   = |(rows[elim_addr] & piv_mask);
  assign search_row = rows[search_addr];
  assign rd_data    = rows[rd_addr];

  // NOTE: the array is reset because a reset must leave every row cleared;
  // the swap relies on non-blocking reads seeing both rows' old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < ROWS; n++) rows[n] <= '0;
    end else if (wr_en) begin
      rows[wr_addr] <= wr_data;
    end else if (swap_en) begin
      rows[swap_a] <= rows[swap_b];
      rows[swap_b] <= rows[swap_a];
    end else if (elim_en && (elim_addr != piv_addr) && elim_hit) begin
      rows[elim_addr] <= rows[elim_addr] ^ rows[piv_addr];
    end
  end

endmodule

// File: rtl/gf2_row_systemizer.sv
// Gauss-Jordan systemizer over GF(2): load ROWS rows, reduce the leading
// ROWS columns to identity, unload. GF2_SYS_CYCLE_COUNT_EN adds cycle_cnt.
module gf2_row_systemizer
  import gf2_sys_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [COLS-1:0] ld_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [COLS-1:0] rd_data,
  output logic            busy,
  output logic            done,
  output logic            success,
  output logic            fail
`ifdef GF2_SYS_CYCLE_COUNT_EN
  ,
  output logic [15:0]     cycle_cnt
`endif
);

  localparam int IW = idx_width(ROWS);
  localparam int AW = addr_width(ROWS);
  localparam logic [IW-1:0] LAST    = IW'(ROWS - 1);
  localparam logic [IW-1:0] FULL    = IW'(ROWS);
  localparam logic [IW-1:0] ONE_IDX = IW'(1);

  state_t          state, state_d;
  logic [IW-1:0]   ld_ptr, ld_ptr_d;
  logic [IW-1:0]   rd_ptr, rd_ptr_d;
  logic [IW-1:0]   piv, piv_d;
  logic [IW-1:0]   k, k_d;
  logic [IW-1:0]   r, r_d;
  logic            done_d, success_d, fail_d;
  logic            start_ok;
  logic            wr_en, swap_en, elim_en;
  logic [COLS-1:0] search_row;
  logic            search_hit;

  assign start_ok   = (state == IDLE) && start && (ld_ptr == FULL);
  assign search_hit = |(search_row & (COLS'(1) << piv));
  assign busy       = (state == SEARCH) || (state == ELIM);
  assign rd_valid   = (state == UNLOAD);
  assign ld_ready   = (state == IDLE) && (ld_ptr < FULL);

  gf2_row_file #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_row_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (AW'(ld_ptr)),
    .wr_data     (ld_data),
    .swap_en     (swap_en),
    .swap_a      (AW'(piv)),
    .swap_b      (AW'(piv + k)),
    .elim_en     (elim_en),
    .elim_addr   (AW'(r)),
    .piv_addr    (AW'(piv)),
    .search_addr (AW'(piv + k)),
    .search_row  (search_row),
    .rd_addr     (AW'(rd_ptr)),
    .rd_data     (rd_data)
  );

  // NOTE: every variable gets its default first so no path infers a latch.
  always_comb begin
    state_d   = state;
    ld_ptr_d  = ld_ptr;
    rd_ptr_d  = rd_ptr;
    piv_d     = piv;
    k_d       = k;
    r_d       = r;
    done_d    = 1'b0;
    success_d = success;
    fail_d    = fail;
    wr_en     = 1'b0;
    swap_en   = 1'b0;
    elim_en   = 1'b0;

    case (state)
      IDLE: begin
        if (ld_valid && ld_ready) begin
          wr_en    = 1'b1;
          ld_ptr_d = ld_ptr + ONE_IDX;
        end
        if (start_ok) begin
          success_d = 1'b0;
          fail_d    = 1'b0;
          piv_d     = '0;
          k_d       = '0;
          state_d   = SEARCH;
        end
      end

      SEARCH: begin
        if (search_hit) begin
          swap_en = 1'b1;
          r_d     = '0;
          state_d = ELIM;
        end else if (k == LAST - piv) begin
          fail_d  = 1'b1;
          done_d  = 1'b1;
          state_d = UNLOAD;
        end else begin
          k_d = k + ONE_IDX;
        end
      end

      ELIM: begin
        elim_en = 1'b1;
        if (r == LAST) begin
          piv_d = piv + ONE_IDX;
          k_d   = '0;
          if (piv == LAST) begin
            success_d = 1'b1;
            done_d    = 1'b1;
            state_d   = UNLOAD;
          end else begin
            state_d = SEARCH;
          end
        end else begin
          r_d = r + ONE_IDX;
        end
      end

      UNLOAD: begin
        if (rd_ready) begin
          if (rd_ptr == LAST) begin
            rd_ptr_d = '0;
            ld_ptr_d = '0;
            state_d  = IDLE;
          end else begin
            rd_ptr_d = rd_ptr + ONE_IDX;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ld_ptr  <= '0;
      rd_ptr  <= '0;
      piv     <= '0;
      k       <= '0;
      r       <= '0;
      done    <= 1'b0;
      success <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state   <= state_d;
      ld_ptr  <= ld_ptr_d;
      rd_ptr  <= rd_ptr_d;
      piv     <= piv_d;
      k       <= k_d;
      r       <= r_d;
      done    <= done_d;
      success <= success_d;
      fail    <= fail_d;
    end
  end

`ifdef GF2_SYS_CYCLE_COUNT_EN
  // Counts SEARCH/ELIM cycles of the current run, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (start_ok) begin
      cycle_cnt <= '0;
    end else if (busy && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gf2_row_systemizer.sv
// Self-checking bench for gf2_row_systemizer (ROWS=4, COLS=8): directed
// table vectors, multi-cycle corner sequences and randomized matrices.
module tb_gf2_row_systemizer;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int MAX_WAIT = 200;

  typedef logic [ROWS-1:0][COLS-1:0] mat_t;

  typedef struct {
    mat_t in_rows;
    mat_t exp_rows;
    bit   exp_succ;
    int   exp_lat;
    int   stall_at;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            ld_valid = 1'b0;
  logic            ld_ready;
  logic [COLS-1:0] ld_data = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [COLS-1:0] rd_data;
  logic            busy, done, success, fail;
`ifdef GF2_SYS_CYCLE_COUNT_EN
  logic [15:0]     cycle_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gf2_row_systemizer #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .success  (success),
    .fail     (fail)
`ifdef GF2_SYS_CYCLE_COUNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_success"},  32'(success),  32'd0);
    check({tag, "_fail"},     32'(fail),     32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
  endtask

  // Reference: plain Gauss-Jordan with the documented timing rules
  // (one cycle per search probe, ROWS cycles per elimination pass).
  function automatic void model(input mat_t m_in, output mat_t m_out,
                                output bit succ, output int lat);
    logic [COLS-1:0] a [ROWS];
    logic [COLS-1:0] t;
    int hit;
    for (int n = 0; n < ROWS; n++) a[n] = m_in[n];
    succ = 1'b1;
    lat  = 0;
    for (int i = 0; i < ROWS && succ; i++) begin
      hit = -1;
      for (int j = i; j < ROWS && hit < 0; j++) begin
        lat++;
        if (a[j][i]) hit = j;
      end
      if (hit < 0) begin
        succ = 1'b0;
      end else begin
        t = a[i]; a[i] = a[hit]; a[hit] = t;
        lat += ROWS;
        for (int q = 0; q < ROWS; q++)
          if (q != i && a[q][i]) a[q] = a[q] ^ a[i];
      end
    end
    for (int n = 0; n < ROWS; n++) m_out[n] = a[n];
  endfunction

  task automatic apply_reset();
    start = 1'b0; ld_valid = 1'b0; rd_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_rows(input mat_t m, input int first, input int count, input string tag);
    for (int n = first; n < first + count; n++) begin
      @(negedge clk);
      check($sformatf("%s_ld_ready_row%0d", tag, n), 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_data  = m[n];
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  // Starts a run on an already loaded matrix, waits for done, unloads.
  task automatic exec(input mat_t exp_rows, input bit exp_succ, input int exp_lat,
                      input int stall_at, input string tag);
    int cnt;
    bit seen;
    logic [COLS-1:0] held;
    check({tag, "_ld_full"}, 32'(ld_ready), 32'd0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < MAX_WAIT) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        ld_valid = busy;
        ld_data  = COLS'($urandom);
        @(posedge clk);
        cnt++;
        @(negedge clk);
      end
    end
    ld_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      apply_reset();
      return;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_success"}, 32'(success), 32'(exp_succ));
    check({tag, "_fail"}, 32'(fail), 32'(!exp_succ));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
`ifdef GF2_SYS_CYCLE_COUNT_EN
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'(exp_lat));
`endif
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_flag_held"}, 32'(success), 32'(exp_succ));
    for (int n = 0; n < ROWS; n++) begin
      check($sformatf("%s_rd_valid%0d", tag, n), 32'(rd_valid), 32'd1);
      check($sformatf("%s_row%0d", tag, n), 32'(rd_data), 32'(exp_rows[n]));
      if (n == stall_at) begin
        rd_ready = 1'b0;
        held = rd_data;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check($sformatf("%s_stall%0d", tag, s), 32'(rd_data), 32'(held));
        end
        check({tag, "_stall_row"}, 32'(rd_data), 32'(exp_rows[n]));
      end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check({tag, "_end_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_end_ld_ready"}, 32'(ld_ready), 32'd1);
  endtask

  vec_t vecs [4];

  initial begin
    mat_t m, exp_m;
    bit   succ;
    int   lat;

    vecs[0] = '{in_rows: {8'h88, 8'h44, 8'h22, 8'h11}, exp_rows: {8'h88, 8'h44, 8'h22, 8'h11},
                exp_succ: 1'b1, exp_lat: 20, stall_at: 1};
    vecs[1] = '{in_rows: {8'h08, 8'h04, 8'h01, 8'h02}, exp_rows: {8'h08, 8'h04, 8'h02, 8'h01},
                exp_succ: 1'b1, exp_lat: 21, stall_at: -1};
    vecs[2] = '{in_rows: {8'h08, 8'h04, 8'h22, 8'h53}, exp_rows: {8'h08, 8'h04, 8'h22, 8'h71},
                exp_succ: 1'b1, exp_lat: 20, stall_at: -1};
    vecs[3] = '{in_rows: {8'h08, 8'h04, 8'h03, 8'h03}, exp_rows: {8'h08, 8'h04, 8'h00, 8'h03},
                exp_succ: 1'b0, exp_lat: 8, stall_at: 3};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int v = 0; v < 4; v++) begin
      load_rows(vecs[v].in_rows, 0, ROWS, $sformatf("vec%0d", v));
      exec(vecs[v].exp_rows, vecs[v].exp_succ, vecs[v].exp_lat, vecs[v].stall_at,
           $sformatf("vec%0d", v));
    end

    // Asynchronous reset in the middle of elimination.
    load_rows(vecs[2].in_rows, 0, ROWS, "midrst");
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst_in");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst_out");

    // Start with only three rows loaded must be ignored.
    m = {8'h80, 8'h04, 8'h02, 8'h01};
    load_rows(m, 0, 3, "short");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("short_busy", 32'(busy), 32'd0);
    end
    check("short_ld_ready", 32'(ld_ready), 32'd1);
    m[3] = 8'h08;
    load_rows(m, 3, 1, "short");
    model(m, exp_m, succ, lat);
    exec(exp_m, succ, lat, -1, "short");

    // Randomized matrices against the reference model.
    for (int t = 0; t < 30; t++) begin
      for (int n = 0; n < ROWS; n++) m[n] = COLS'($urandom);
      if (t % 3 == 0)
        for (int n = 0; n < ROWS; n++) m[n][n] = 1'b1;
      model(m, exp_m, succ, lat);
      load_rows(m, 0, ROWS, $sformatf("rnd%0d", t));
      exec(exp_m, succ, lat, (t % 5 == 0) ? int'($urandom_range(0, ROWS - 1)) : -1,
           $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
